// File: rtl/imm_enc_pkg.sv
// Shared definitions for the immediate encoder: format codes (common with the
// immediate generator), RV32 base opcodes and the default NOP word.
package imm_enc_pkg;

  // Immediate format codes; encodings are shared with the immediate generator.
  typedef enum logic [2:0] {
    IMM_I   = 3'd0,
    IMM_S   = 3'd1,
    IMM_B   = 3'd2,
    IMM_U   = 3'd3,
    IMM_J   = 3'd4,
    IMM_C   = 3'd5,
    IMM_SH  = 3'd6,
    IMM_INV = 3'b111
  } imm_fmt_e;

  // RV32I base opcodes.
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN_DEFAULT = 32'h0000_0013;

  // Decoded instruction fields as held in the first pipeline stage.
  typedef struct packed {
    logic [2:0]  imm_op;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] csr;
  } enc_fields_t;

endpackage

// File: rtl/imm_enc_pack.sv
// Combinational RV32 field packer with immediate range check.
// Range checking is compiled in only when IMM_ENC_RANGE_CHECK_EN is defined;
// otherwise range_err is constant 0.
module imm_enc_pack
  import imm_enc_pkg::*;
#(
  parameter logic [31:0] NOP_INSN = NOP_INSN_DEFAULT
) (
  input  logic [2:0]  imm_op,
  input  logic [31:0] imm,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [11:0] csr,
  output logic [31:0] insn,
  output logic        range_err
);

  imm_fmt_e fmt;
  assign fmt = imm_fmt_e'(imm_op);

  // Scatter the immediate bits into the instruction layout of each format.
  always_comb begin
    insn = NOP_INSN;
    case (fmt)
      IMM_I:   insn = {imm[11:0], rs1, funct3, rd, opcode};
      IMM_S:   insn = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      IMM_B:   insn = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      IMM_U:   insn = {imm[31:12], rd, opcode};
      IMM_J:   insn = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      IMM_C:   insn = {csr, imm[4:0], funct3, rd, opcode};
      IMM_SH:  insn = {funct7, imm[4:0], rs1, funct3, rd, opcode};
      default: insn = NOP_INSN;
    endcase
  end

`ifdef IMM_ENC_RANGE_CHECK_EN
  // Flag immediates that do not survive truncation into the format's field.
  always_comb begin
    range_err = 1'b0;
    case (fmt)
      IMM_I, IMM_S:  range_err = (imm != {{20{imm[11]}}, imm[11:0]});
      IMM_B:         range_err = (imm != {{19{imm[12]}}, imm[12:0]}) | imm[0];
      IMM_J:         range_err = (imm != {{11{imm[20]}}, imm[20:0]}) | imm[0];
      IMM_U:         range_err = |imm[11:0];
      IMM_C, IMM_SH: range_err = |imm[31:5];
      default:       range_err = 1'b1;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: rtl/imm_enc.sv
// Immediate encoder / instruction assembler: 2-stage valid/ready pipeline that
// packs decoded fields into a 32-bit RV32 instruction word.
// Optional feature macro: IMM_ENC_RANGE_CHECK_EN (range flag and error counter).
module imm_enc
  import imm_enc_pkg::*;
#(
  parameter int          ERR_CNT_W = 8,
  parameter logic [31:0] NOP_INSN  = NOP_INSN_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [2:0]           imm_op_i,
  input  logic [31:0]          imm_i,
  input  logic [6:0]           opcode_i,
  input  logic [4:0]           rd_i,
  input  logic [4:0]           rs1_i,
  input  logic [4:0]           rs2_i,
  input  logic [2:0]           funct3_i,
  input  logic [6:0]           funct7_i,
  input  logic [11:0]          csr_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [31:0]          instruction_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  enc_fields_t s1_f;
  logic        s1_valid;
  logic        s2_valid;
  logic [31:0] s2_insn;
  logic        s2_err;
  logic        s1_adv;
  logic        s2_adv;
  logic [31:0] pack_insn;
  logic        pack_err;

  assign s2_adv     = ~s2_valid | out_ready_i;
  assign s1_adv     = ~s1_valid | s2_adv;
  assign in_ready_o = ~s1_valid | s1_adv;

  // Stage 1: capture the raw fields whenever the stage can take a new word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_f     <= '0;
    end else if (in_ready_o) begin
      s1_valid <= in_valid_i;
      if (in_valid_i) begin
        s1_f <= '{imm_op: imm_op_i, imm: imm_i, opcode: opcode_i, rd: rd_i,
                  rs1: rs1_i, rs2: rs2_i, funct3: funct3_i, funct7: funct7_i,
                  csr: csr_i};
      end
    end
  end

  imm_enc_pack #(
    .NOP_INSN(NOP_INSN)
  ) u_pack (
    .imm_op    (s1_f.imm_op),
    .imm       (s1_f.imm),
    .opcode    (s1_f.opcode),
    .rd        (s1_f.rd),
    .rs1       (s1_f.rs1),
    .rs2       (s1_f.rs2),
    .funct3    (s1_f.funct3),
    .funct7    (s1_f.funct7),
    .csr       (s1_f.csr),
    .insn      (pack_insn),
    .range_err (pack_err)
  );

  // Stage 2: hold the packed word; frozen while the output is stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      s2_insn  <= '0;
      s2_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_insn <= pack_insn;
        s2_err  <= pack_err;
      end
    end
  end

  assign out_valid_o   = s2_valid;
  assign instruction_o = s2_insn;
  assign err_o         = s2_err;

`ifdef IMM_ENC_RANGE_CHECK_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Count errored words on transfer, saturating at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (s2_valid & out_ready_i & s2_err & ~(&err_cnt_q)) begin
      err_cnt_q <= err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule
